// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - sequential reverse double-dabble BCD-to-binary converter
// Optional BCD_RANGE_CHECK_EN: digits > 9 raise err with done and force bin_out to 0.
module bcd_to_binary #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [SR_W-1:0]  sr, sr_nx, sr_step;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ld_result;

  // One iteration: shift right, then pull every BCD digit that reached >= 8 back by 3.
  always_comb begin
    sr_step = sr >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_step[BIN_W + 4*d + 3]) begin
        sr_step[BIN_W + 4*d +: 4] = sr_step[BIN_W + 4*d +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    sr_nx     = sr;
    cnt_nx    = cnt;
    ld_result = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sr_nx    = {bcd_in, {BIN_W{1'b0}}};
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy   = 1'b1;
        sr_nx  = sr_step;
        cnt_nx = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          ld_result = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      cnt   <= cnt_nx;
    end
  end

`ifdef BCD_RANGE_CHECK_EN
  logic bad_in, bad_q, err_q;

  always_comb begin
    bad_in = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) begin
        bad_in = 1'b1;
      end
    end
  end

  // Captured with the operand so later bcd_in changes cannot affect the verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 1'b0;
    end else if (state == IDLE && start) begin
      bad_q <= bad_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (ld_result) begin
      err_q <= bad_q;
    end
  end

  assign err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out <= '0;
    end else if (ld_result) begin
      bin_out <= bad_q ? '0 : sr_step[BIN_W-1:0];
    end
  end
`else
  assign err = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out <= '0;
    end else if (ld_result) begin
      bin_out <= sr_step[BIN_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb/tb_bcd_to_binary.sv - randomized self-checking bench for bcd_to_binary
// Define BCD_RANGE_CHECK_EN to exercise the digit range check.
module tb_bcd_to_binary;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] bcd_in = 12'h000;
  logic        busy, done, err;
  logic [9:0]  bin_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [9:0] last_res = 10'd0;

  bcd_to_binary #(.DIGITS(3), .BIN_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_val(input logic [11:0] b);
    int v = 0;
    for (int i = 2; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [11:0] rand_bcd();
    logic [11:0] b;
    for (int i = 0; i < 3; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
    return b;
  endfunction

  // Starts one conversion and waits (bounded) for done; bcd_in is scrambled after acceptance.
  task automatic run_conv(input logic [11:0] b, output int lat, output int busy_n,
                          output logic [9:0] res, output logic e, output logic held_ok);
    @(posedge clk); #1;
    start = 1'b1; bcd_in = b;
    @(posedge clk); #1;
    start = 1'b0; bcd_in = rand_bcd();
    lat = 0; busy_n = 0; held_ok = 1'b1;
    while (lat <= 30) begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_n++;
      if (bin_out !== last_res) held_ok = 1'b0;
      @(posedge clk);
      lat++;
    end
    res = bin_out; e = err;
    last_res = bin_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; bcd_in = 12'h999;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (bin_out !== 10'd0) begin failures++; $display("FAIL reset_bin: got %0d expected 0", bin_out); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
    start = 1'b0;
    rst_n = 1'b1;
    last_res = 10'd0;
  endtask

  task automatic test_basic();
    logic [11:0] vec [3];
    int lat, bn;
    logic [9:0] res;
    logic e, held;
    vec[0] = 12'h239; vec[1] = 12'h999; vec[2] = 12'h000;
    for (int i = 0; i < 3; i++) begin
      run_conv(vec[i], lat, bn, res, e, held);
      checks++; if (res !== 10'(ref_val(vec[i]))) begin failures++; $display("FAIL basic_value %h: got %0d expected %0d", vec[i], res, ref_val(vec[i])); end
      checks++; if (lat != 10) begin failures++; $display("FAIL basic_latency %h: got %0d expected 10", vec[i], lat); end
      checks++; if (bn != 10) begin failures++; $display("FAIL basic_busy_cycles %h: got %0d expected 10", vec[i], bn); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL basic_err %h: got %b expected 0", vec[i], e); end
      checks++; if (held !== 1'b1) begin failures++; $display("FAIL basic_bin_held %h: got %b expected 1", vec[i], held); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || bin_out !== res) begin failures++; $display("FAIL basic_done_pulse %h: got done=%b bin=%0d expected done=0 bin=%0d", vec[i], done, bin_out, res); end
    end
  endtask

  task automatic test_random();
    logic [11:0] b;
    int lat, bn;
    logic [9:0] res;
    logic e, held;
    for (int i = 0; i < 16; i++) begin
      b = rand_bcd();
      run_conv(b, lat, bn, res, e, held);
      checks++; if (res !== 10'(ref_val(b)) || e !== 1'b0) begin failures++; $display("FAIL random_value %h: got %0d err=%b expected %0d err=0", b, res, e, ref_val(b)); end
      checks++; if (lat != 10 || held !== 1'b1) begin failures++; $display("FAIL random_timing %h: got lat=%0d held=%b expected lat=10 held=1", b, lat, held); end
    end
  endtask

  task automatic test_back_to_back();
    int t1 = 0, t2 = 0;
    logic [9:0] r1 = '0, r2 = '0;
    @(posedge clk); #1;
    start = 1'b1; bcd_in = 12'h111;
    @(posedge clk); #1;
    bcd_in = 12'h255;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin t1 = cyc; r1 = bin_out; break; end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) break;
    end
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin t2 = cyc; r2 = bin_out; break; end
    end
    last_res = bin_out;
    checks++; if (r1 !== 10'(ref_val(12'h111))) begin failures++; $display("FAIL b2b_first: got %0d expected 111", r1); end
    checks++; if (r2 !== 10'(ref_val(12'h255))) begin failures++; $display("FAIL b2b_second: got %0d expected 255", r2); end
    checks++; if (t2 - t1 != 12) begin failures++; $display("FAIL b2b_spacing: got %0d expected 12", t2 - t1); end
  endtask

  task automatic test_start_ignored();
    int t0, t1 = -100, extra = 0;
    logic [9:0] r = '0;
    @(posedge clk); #1;
    start = 1'b1; bcd_in = 12'h123;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; start = 1'b1; bcd_in = 12'h456;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin t1 = cyc; r = bin_out; break; end
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    last_res = bin_out;
    checks++; if (r !== 10'(ref_val(12'h123))) begin failures++; $display("FAIL ignored_value: got %0d expected 123", r); end
    checks++; if (t1 - t0 != 10) begin failures++; $display("FAIL ignored_latency: got %0d expected 10", t1 - t0); end
    checks++; if (extra != 0) begin failures++; $display("FAIL ignored_extra_activity: got %0d expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int stray = 0, lat, bn;
    logic [9:0] res;
    logic e, held;
    @(posedge clk); #1;
    start = 1'b1; bcd_in = 12'h999;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midreset_flags: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (bin_out !== 10'd0) begin failures++; $display("FAIL midreset_bin: got %0d expected 0", bin_out); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 10'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || done || bin_out !== 10'd0) stray++;
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL midreset_stray: got %0d expected 0", stray); end
    run_conv(12'h042, lat, bn, res, e, held);
    checks++; if (res !== 10'd42 || lat != 10) begin failures++; $display("FAIL midreset_after: got %0d lat=%0d expected 42 lat=10", res, lat); end
  endtask

  task automatic test_range_check();
    int lat, bn;
    logic [9:0] res;
    logic e, held;
    run_conv(12'h1A5, lat, bn, res, e, held);
`ifdef BCD_RANGE_CHECK_EN
    checks++; if (e !== 1'b1 || res !== 10'd0) begin failures++; $display("FAIL range_bad: got err=%b bin=%0d expected err=1 bin=0", e, res); end
`else
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL range_err_tied: got %b expected 0", e); end
`endif
    checks++; if (lat != 10) begin failures++; $display("FAIL range_latency: got %0d expected 10", lat); end
    run_conv(12'h105, lat, bn, res, e, held);
    checks++; if (e !== 1'b0 || res !== 10'd105) begin failures++; $display("FAIL range_good: got err=%b bin=%0d expected err=0 bin=105", e, res); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_range_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
